core_id_issue_ctrl: RTL and testbench

Issue controller between the decode stage and the execute stage. It takes the decoded instruction's register indices and class flags and decides, each cycle, whether that instruction may issue to EX. Issue is held off by three things: read-after-write and write-after-write hazards against long-latency writebacks (loads, CSR reads), a cap on LSU transactions in flight, and a drain sequence before fence, fence.i, ecall, ebreak and mret. Instruction data is not registered here; the block owns only the handshake and the hazard state.

---
 rtl/core_id_issue_ctrl_pkg.sv | 47 ++++
 rtl/core_issue_scoreboard.sv | 70 +++++++
 rtl/core_id_issue_ctrl.sv | 178 +++++++++++++++++
 tb/tb_core_id_issue_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_id_issue_ctrl_pkg.sv
// core_id_issue_ctrl_pkg
//   Shared definitions for the ID-stage issue controller and its scoreboard.
//   Holds the register-index width, the FSM state encodings, the width of the
//   outstanding-LSU counter and a helper that turns a register index into a
//   pending-write mask.
//   No ports (package).

`ifndef CORE_RFIDX_WIDTH
`define CORE_RFIDX_WIDTH 5
`endif
`ifndef CORE_ISSUE_ST_RUN
`define CORE_ISSUE_ST_RUN 2'd0
`endif
`ifndef CORE_ISSUE_ST_DRAIN
`define CORE_ISSUE_ST_DRAIN 2'd1
`endif
`ifndef CORE_ISSUE_ST_ISSUE
`define CORE_ISSUE_ST_ISSUE 2'd2
`endif
`ifndef CORE_ISSUE_OUTS_WIDTH
`define CORE_ISSUE_OUTS_WIDTH 3
`endif

package core_id_issue_ctrl_pkg;

  localparam int RFIDX_W  = `CORE_RFIDX_WIDTH;
  localparam int NUM_REGS = 1 << RFIDX_W;
  localparam int OUTS_W   = `CORE_ISSUE_OUTS_WIDTH;

  typedef enum logic [1:0] {
    ISSUE_ST_RUN   = `CORE_ISSUE_ST_RUN,
    ISSUE_ST_DRAIN = `CORE_ISSUE_ST_DRAIN,
    ISSUE_ST_ISSUE = `CORE_ISSUE_ST_ISSUE
  } issue_state_e;

  // One-hot mask over x1..x31; x0 has no bit so it can never be marked pending.
  function automatic logic [NUM_REGS-1:1] reg_mask(input logic [RFIDX_W-1:0] idx,
                                                   input logic en);
    logic [NUM_REGS-1:1] m;
    m = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      m[i] = en & (idx == RFIDX_W'(i));
    end
    return m;
  endfunction

endpackage

// File: rtl/core_issue_scoreboard.sv
// core_issue_scoreboard
//   Pending-write scoreboard for long-latency writebacks (loads, CSR reads).
//   One bit per architectural register x1..x31. A same-cycle writeback is
//   bypassed into the hazard outputs so the dependent instruction issues in
//   the writeback cycle. When the same index is set and cleared together the
//   set wins.
// Ports
//   clk, rst              clock, synchronous active-high reset
//   set_i, set_idx_i      mark register pending (long op issued)
//   clr_i, clr_idx_i      writeback releases register
//   rs1/rs2_ren_i/_idx_i  source operand read ports
//   rd_wen_i, rd_idx_i    destination write port
//   raw_o, waw_o          combinational hazard flags
//   busy_o                any bit pending (registered view)
//   empty_eff_o           no bit pending after this cycle's clear

module core_issue_scoreboard
  import core_id_issue_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               set_i,
  input  logic [RFIDX_W-1:0] set_idx_i,
  input  logic               clr_i,
  input  logic [RFIDX_W-1:0] clr_idx_i,
  input  logic               rs1_ren_i,
  input  logic [RFIDX_W-1:0] rs1_idx_i,
  input  logic               rs2_ren_i,
  input  logic [RFIDX_W-1:0] rs2_idx_i,
  input  logic               rd_wen_i,
  input  logic [RFIDX_W-1:0] rd_idx_i,
  output logic               raw_o,
  output logic               waw_o,
  output logic               busy_o,
  output logic               empty_eff_o
);

  logic [NUM_REGS-1:1] sb_q;
  logic [NUM_REGS-1:1] sb_d;
  logic [NUM_REGS-1:1] set_mask;
  logic [NUM_REGS-1:1] clr_mask;
  logic [NUM_REGS-1:1] sb_eff;
  logic [NUM_REGS-1:0] sb_eff_full;

  // Apply the clear first, then the set, so a set on the same index survives.
  // sb_eff_full re-inserts a constant-zero x0 slot so lookups on index 0 read 0.
  always_comb begin
    set_mask    = reg_mask(set_idx_i, set_i);
    clr_mask    = reg_mask(clr_idx_i, clr_i);
    sb_eff      = sb_q & ~clr_mask;
    sb_eff_full = {sb_eff, 1'b0};
    sb_d        = sb_eff | set_mask;
  end

  // Pending-write register.
  always_ff @(posedge clk) begin
    if (rst) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

  assign raw_o       = (rs1_ren_i & sb_eff_full[rs1_idx_i]) |
                       (rs2_ren_i & sb_eff_full[rs2_idx_i]);
  assign waw_o       = rd_wen_i & sb_eff_full[rd_idx_i];
  assign busy_o      = |sb_q;
  assign empty_eff_o = ~|sb_eff;

endmodule

// File: rtl/core_id_issue_ctrl.sv
// core_id_issue_ctrl
//   Decode-to-execute issue controller. Decides each cycle whether the
//   decoded instruction may issue, holding it off for RAW/WAW hazards against
//   long-latency writebacks, for a cap on in-flight LSU transactions, and for
//   a drain sequence ahead of serialising instructions (fence, fence.i,
//   ecall, ebreak, mret). Only handshake and hazard state live here.
// Optional feature
//   CORE_ISSUE_STALL_CNT_EN : adds o_stall_cnt, a 32-bit stall-cycle counter.
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   i_id_valid / o_id_ready       decode-side handshake
//   o_ex_valid / i_ex_ready       execute-side handshake
//   i_rs1_ren/idx, i_rs2_ren/idx  source operands
//   i_rd_wen/idx                  destination
//   i_is_load/store/csr/serial    instruction class
//   i_wb_valid, i_wb_idx          long-latency writeback
//   i_lsu_done                    one LSU transaction retired
//   i_flush                       kill the instruction in ID
//   o_sb_busy                     scoreboard or LSU activity pending
//   o_stall_cnt                   stall-cycle counter (optional)

module core_id_issue_ctrl
  import core_id_issue_ctrl_pkg::*;
#(
  parameter int unsigned OUTS_MAX = 4
)
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_id_valid,
  output logic               o_id_ready,
  output logic               o_ex_valid,
  input  logic               i_ex_ready,
  input  logic               i_rs1_ren,
  input  logic               i_rs2_ren,
  input  logic               i_rd_wen,
  input  logic [RFIDX_W-1:0] i_rs1_idx,
  input  logic [RFIDX_W-1:0] i_rs2_idx,
  input  logic [RFIDX_W-1:0] i_rd_idx,
  input  logic               i_is_load,
  input  logic               i_is_store,
  input  logic               i_is_csr,
  input  logic               i_is_serial,
  input  logic               i_wb_valid,
  input  logic [RFIDX_W-1:0] i_wb_idx,
  input  logic               i_lsu_done,
  input  logic               i_flush,
  output logic               o_sb_busy
`ifdef CORE_ISSUE_STALL_CNT_EN
  ,
  output logic [31:0]        o_stall_cnt
`endif
);

  issue_state_e      state_q;
  issue_state_e      state_d;
  logic [OUTS_W-1:0] outs_q;
  logic [OUTS_W-1:0] outs_d;

  logic raw;
  logic waw;
  logic sb_busy;
  logic sb_empty_eff;
  logic lsu_op;
  logic lsu_stall;
  logic lsu_inc;
  logic lsu_dec;
  logic long_op;
  logic stall;
  logic issue;
  logic drain_done;

  core_issue_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_i       (long_op),
    .set_idx_i   (i_rd_idx),
    .clr_i       (i_wb_valid),
    .clr_idx_i   (i_wb_idx),
    .rs1_ren_i   (i_rs1_ren),
    .rs1_idx_i   (i_rs1_idx),
    .rs2_ren_i   (i_rs2_ren),
    .rs2_idx_i   (i_rs2_idx),
    .rd_wen_i    (i_rd_wen),
    .rd_idx_i    (i_rd_idx),
    .raw_o       (raw),
    .waw_o       (waw),
    .busy_o      (sb_busy),
    .empty_eff_o (sb_empty_eff)
  );

  assign lsu_op    = i_is_load | i_is_store;
  assign lsu_stall = lsu_op & (outs_q == OUTS_W'(OUTS_MAX));

  // Issue decision and handshake. Serial instructions are held in RUN so they
  // always pass through DRAIN; outputs are forced quiet while reset is held.
  always_comb begin
    stall = raw | waw | lsu_stall |
            (state_q == ISSUE_ST_DRAIN) |
            ((state_q == ISSUE_ST_RUN) & i_is_serial);
    issue      = ~rst & i_id_valid & i_ex_ready & ~stall & ~i_flush;
    long_op    = issue & i_rd_wen & (i_is_load | i_is_csr);
    o_ex_valid = issue;
    o_id_ready = ~rst & ((i_ex_ready & ~stall) | i_flush);
    o_sb_busy  = ~rst & (sb_busy | (outs_q != '0));
  end

  // Outstanding LSU counter next state. A retire with nothing outstanding is
  // ignored so the count never wraps below zero.
  always_comb begin
    lsu_inc = issue & lsu_op;
    lsu_dec = i_lsu_done & (outs_q != '0);
    outs_d  = outs_q;
    if (lsu_inc && !lsu_dec) begin
      outs_d = outs_q + OUTS_W'(1);
    end else if (!lsu_inc && lsu_dec) begin
      outs_d = outs_q - OUTS_W'(1);
    end
  end

  // Nothing issues while draining, so the post-clear counter and scoreboard
  // tell us whether the pipeline will be empty at the next edge.
  assign drain_done = sb_empty_eff & (outs_d == '0);

  // FSM next state. DRAIN may complete even while EX is not ready; a flush
  // abandons the serial instruction from either waiting state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ISSUE_ST_RUN: begin
        if (i_id_valid && i_is_serial && !i_flush && i_ex_ready) begin
          state_d = ISSUE_ST_DRAIN;
        end
      end
      ISSUE_ST_DRAIN: begin
        if (i_flush) begin
          state_d = ISSUE_ST_RUN;
        end else if (drain_done) begin
          state_d = ISSUE_ST_ISSUE;
        end
      end
      ISSUE_ST_ISSUE: begin
        if (i_flush || issue) begin
          state_d = ISSUE_ST_RUN;
        end
      end
      default: state_d = ISSUE_ST_RUN;
    endcase
  end

  // State register and LSU counter. Flush leaves the counter alone because
  // in-flight transactions still retire.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ISSUE_ST_RUN;
      outs_q  <= '0;
    end else begin
      state_q <= state_d;
      outs_q  <= outs_d;
    end
  end

`ifdef CORE_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  // Counts cycles a live, unflushed instruction is held in ID; wraps freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
    end else if (i_id_valid && !i_flush && stall) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign o_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_core_id_issue_ctrl.sv
// tb_core_id_issue_ctrl
//   Directed bench for core_id_issue_ctrl with OUTS_MAX = 4. Inputs change
//   1 time unit after the rising edge; outputs are sampled 2 units later.

module tb_core_id_issue_ctrl;
  import core_id_issue_ctrl_pkg::*;

  logic clk;
  logic rst;
  logic id_valid;
  logic id_ready;
  logic ex_valid;
  logic ex_ready;
  logic rs1_ren;
  logic rs2_ren;
  logic rd_wen;
  logic [RFIDX_W-1:0] rs1_idx;
  logic [RFIDX_W-1:0] rs2_idx;
  logic [RFIDX_W-1:0] rd_idx;
  logic is_load;
  logic is_store;
  logic is_csr;
  logic is_serial;
  logic wb_valid;
  logic [RFIDX_W-1:0] wb_idx;
  logic lsu_done;
  logic flush;
  logic sb_busy;
`ifdef CORE_ISSUE_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int checks;
  int errors;

  core_id_issue_ctrl #(.OUTS_MAX(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .i_id_valid  (id_valid),
    .o_id_ready  (id_ready),
    .o_ex_valid  (ex_valid),
    .i_ex_ready  (ex_ready),
    .i_rs1_ren   (rs1_ren),
    .i_rs2_ren   (rs2_ren),
    .i_rd_wen    (rd_wen),
    .i_rs1_idx   (rs1_idx),
    .i_rs2_idx   (rs2_idx),
    .i_rd_idx    (rd_idx),
    .i_is_load   (is_load),
    .i_is_store  (is_store),
    .i_is_csr    (is_csr),
    .i_is_serial (is_serial),
    .i_wb_valid  (wb_valid),
    .i_wb_idx    (wb_idx),
    .i_lsu_done  (lsu_done),
    .i_flush     (flush),
    .o_sb_busy   (sb_busy)
`ifdef CORE_ISSUE_STALL_CNT_EN
    ,
    .o_stall_cnt (stall_cnt)
`endif
  );

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts the check and reports a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic checkIssue(input string tag, input logic expEx, input logic expRdy);
    checkOutput({tag, "_ex_valid"}, {31'd0, ex_valid}, {31'd0, expEx});
    checkOutput({tag, "_id_ready"}, {31'd0, id_ready}, {31'd0, expRdy});
  endtask

  // Drives the decoded-instruction fields.
  task automatic applyStimulus(input logic v, input logic r1en, input int r1,
                               input logic r2en, input int r2, input logic rden,
                               input int rd, input logic ld, input logic st,
                               input logic csr, input logic ser);
    id_valid  = v;
    rs1_ren   = r1en;
    rs1_idx   = RFIDX_W'(r1);
    rs2_ren   = r2en;
    rs2_idx   = RFIDX_W'(r2);
    rd_wen    = rden;
    rd_idx    = RFIDX_W'(rd);
    is_load   = ld;
    is_store  = st;
    is_csr    = csr;
    is_serial = ser;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic lw(input int rd, input int rs1);
    applyStimulus(1'b1, 1'b1, rs1, 1'b0, 0, 1'b1, rd, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic sw(input int rs1, input int rs2);
    applyStimulus(1'b1, 1'b1, rs1, 1'b1, rs2, 1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask
  task automatic addI(input int rd, input int rs1, input int rs2);
    applyStimulus(1'b1, 1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic serialI();
    applyStimulus(1'b1, 1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  // Advance past the next rising edge and drop the single-cycle pulses.
  task automatic nextCycle();
    @(posedge clk);
    #1;
    wb_valid = 1'b0;
    wb_idx   = '0;
    lsu_done = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    ex_ready = 1'b1;
    wb_valid = 1'b0;
    wb_idx   = '0;
    lsu_done = 1'b0;
    flush    = 1'b0;
    idle();

    // Reset with a store presented: nothing may issue or handshake.
    sw(1, 2);
    nextCycle(); settle();
    checkIssue("rst", 1'b0, 1'b0);
    checkOutput("rst_sb_busy", {31'd0, sb_busy}, 32'd0);
`ifdef CORE_ISSUE_STALL_CNT_EN
    checkOutput("rst_stall_cnt", stall_cnt, 32'd0);
`endif
    nextCycle(); rst = 1'b0; idle(); settle();
    checkIssue("idle", 1'b0, 1'b1);
    checkOutput("idle_sb_busy", {31'd0, sb_busy}, 32'd0);

    // RAW on load, released by a same-cycle writeback.
    nextCycle(); lw(5, 1); settle();
    checkIssue("raw_lw", 1'b1, 1'b1);
    nextCycle(); addI(6, 5, 1); settle();
    checkIssue("raw_stall0", 1'b0, 1'b0);
    checkOutput("raw_sb_busy", {31'd0, sb_busy}, 32'd1);
    nextCycle(); settle();
    checkIssue("raw_stall1", 1'b0, 1'b0);
    nextCycle(); wb_valid = 1'b1; wb_idx = 5'd5; settle();
    checkIssue("raw_wb_bypass", 1'b1, 1'b1);
    nextCycle(); idle(); lsu_done = 1'b1; settle();
    nextCycle(); settle();
    checkOutput("raw_drained", {31'd0, sb_busy}, 32'd0);

    // x0 destination never marks a hazard.
    nextCycle(); lw(0, 1); settle();
    checkIssue("x0_lw", 1'b1, 1'b1);
    nextCycle(); addI(7, 0, 0); settle();
    checkIssue("x0_dep", 1'b1, 1'b1);
    nextCycle(); idle(); lsu_done = 1'b1; settle();

    // Same-cycle set and clear of x5: set wins.
    nextCycle(); lw(5, 2); settle();
    checkIssue("coll_lw_a", 1'b1, 1'b1);
    nextCycle(); lw(5, 2); wb_valid = 1'b1; wb_idx = 5'd5; settle();
    checkIssue("coll_lw_b", 1'b1, 1'b1);
    nextCycle(); addI(6, 5, 0); settle();
    checkIssue("coll_sb5_set", 1'b0, 1'b0);
    nextCycle(); addI(6, 5, 0); wb_valid = 1'b1; wb_idx = 5'd5; settle();
    checkIssue("coll_release", 1'b1, 1'b1);
    nextCycle(); idle(); lsu_done = 1'b1; settle();
    nextCycle(); lsu_done = 1'b1; settle();
    nextCycle(); settle();
    checkOutput("coll_drained", {31'd0, sb_busy}, 32'd0);

    // WAW on a pending destination.
    nextCycle(); lw(8, 1); settle();
    checkIssue("waw_lw", 1'b1, 1'b1);
    nextCycle(); addI(8, 1, 2); settle();
    checkIssue("waw_stall", 1'b0, 1'b0);
    nextCycle(); wb_valid = 1'b1; wb_idx = 5'd8; settle();
    checkIssue("waw_release", 1'b1, 1'b1);
    nextCycle(); idle(); lsu_done = 1'b1; settle();

    // Retire with nothing outstanding is ignored (no wrap to 7).
    nextCycle(); lsu_done = 1'b1; settle();
    nextCycle(); sw(1, 2); settle();
    checkIssue("sat_store", 1'b1, 1'b1);
    nextCycle(); idle(); settle();
    checkOutput("sat_busy", {31'd0, sb_busy}, 32'd1);
    nextCycle(); lsu_done = 1'b1; settle();
    nextCycle(); settle();
    checkOutput("sat_drained", {31'd0, sb_busy}, 32'd0);

    // Outstanding cap of 4.
    for (int i = 0; i < 4; i++) begin
      nextCycle(); sw(1, 2); settle();
      checkIssue("cap_store", 1'b1, 1'b1);
    end
    nextCycle(); settle();
    checkIssue("cap_full", 1'b0, 1'b0);
    nextCycle(); lsu_done = 1'b1; settle();
    nextCycle(); settle();
    checkIssue("cap_after_done", 1'b1, 1'b1);
    for (int i = 0; i < 4; i++) begin
      nextCycle(); idle(); lsu_done = 1'b1; settle();
    end
    nextCycle(); settle();
    checkOutput("cap_drained", {31'd0, sb_busy}, 32'd0);

    // Serial instruction on an empty pipeline: RUN, DRAIN, ISSUE.
    nextCycle(); serialI(); settle();
    checkIssue("ser_run", 1'b0, 1'b0);
    nextCycle(); settle();
    checkIssue("ser_drain", 1'b0, 1'b0);
    nextCycle(); settle();
    checkIssue("ser_issue", 1'b1, 1'b1);

    // Fence drain with x3 pending and two LSU ops in flight.
    nextCycle(); lw(3, 1); settle();
    checkIssue("fd_lw", 1'b1, 1'b1);
    nextCycle(); sw(1, 2); settle();
    checkIssue("fd_sw", 1'b1, 1'b1);
    nextCycle(); serialI(); settle();
    checkIssue("fd_run", 1'b0, 1'b0);
    nextCycle(); settle();
    checkIssue("fd_drain0", 1'b0, 1'b0);
    nextCycle(); wb_valid = 1'b1; wb_idx = 5'd3; settle();
    checkIssue("fd_drain_wb", 1'b0, 1'b0);
    nextCycle(); lsu_done = 1'b1; settle();
    checkIssue("fd_drain_d1", 1'b0, 1'b0);
    nextCycle(); lsu_done = 1'b1; settle();
    checkIssue("fd_drain_d2", 1'b0, 1'b0);
    nextCycle(); settle();
    checkIssue("fd_issue", 1'b1, 1'b1);
    checkOutput("fd_sb_busy", {31'd0, sb_busy}, 32'd0);
    nextCycle(); serialI(); settle();
    checkIssue("fd_back_run", 1'b0, 1'b0);
    nextCycle(); settle();
    nextCycle(); settle();
    checkIssue("fd_second", 1'b1, 1'b1);

    // Flush during drain keeps the outstanding count.
    nextCycle(); sw(1, 2); settle();
    checkIssue("fl_sw", 1'b1, 1'b1);
    nextCycle(); serialI(); settle();
    checkIssue("fl_run", 1'b0, 1'b0);
    nextCycle(); flush = 1'b1; settle();
    checkIssue("fl_drain", 1'b0, 1'b1);
    nextCycle(); addI(6, 1, 2); settle();
    checkIssue("fl_back_run", 1'b1, 1'b1);
    checkOutput("fl_keeps_outs", {31'd0, sb_busy}, 32'd1);
    nextCycle(); addI(6, 1, 2); flush = 1'b1; settle();
    checkIssue("fl_in_run", 1'b0, 1'b1);
    nextCycle(); idle(); lsu_done = 1'b1; settle();

    // EX not ready blocks issue and decode.
    nextCycle(); addI(6, 1, 2); ex_ready = 1'b0; settle();
    checkIssue("exr_low", 1'b0, 1'b0);
    nextCycle(); ex_ready = 1'b1; idle(); settle();

    // Reset in the middle of a drain.
    nextCycle(); lw(9, 1); settle();
    checkIssue("rd_lw", 1'b1, 1'b1);
    nextCycle(); serialI(); settle();
    nextCycle(); settle();
    checkIssue("rd_drain", 1'b0, 1'b0);
    nextCycle(); rst = 1'b1; idle(); settle();
    checkOutput("rd_rst_busy", {31'd0, sb_busy}, 32'd0);
    nextCycle(); rst = 1'b0; wb_valid = 1'b1; wb_idx = 5'd9; settle();
    checkOutput("rd_busy_after", {31'd0, sb_busy}, 32'd0);
    nextCycle(); addI(10, 9, 0); settle();
    checkIssue("rd_sb_cleared", 1'b1, 1'b1);

    // Seven-cycle RAW stall for the optional counter.
    nextCycle(); rst = 1'b1; idle(); settle();
    nextCycle(); rst = 1'b0; settle();
`ifdef CORE_ISSUE_STALL_CNT_EN
    checkOutput("cnt_zero", stall_cnt, 32'd0);
`endif
    nextCycle(); lw(5, 1); settle();
    checkIssue("cnt_lw", 1'b1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      nextCycle(); addI(6, 5, 1); settle();
      checkIssue("cnt_stall", 1'b0, 1'b0);
    end
    nextCycle(); wb_valid = 1'b1; wb_idx = 5'd5; settle();
    checkIssue("cnt_release", 1'b1, 1'b1);
    nextCycle(); idle(); settle();
`ifdef CORE_ISSUE_STALL_CNT_EN
    checkOutput("cnt_seven", stall_cnt, 32'd7);
    nextCycle(); rst = 1'b1; settle();
    nextCycle(); rst = 1'b0; settle();
    checkOutput("cnt_reset", stall_cnt, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
